// File: rtl/apb_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// apb_reg_bank_pkg
// Shared constants and types for the APB register bank.
//   REG_STRIDE           : byte distance between consecutive registers
//   apb_reg_bank_state_e : access-controller FSM states
//   dec_err_e            : decode outcome of a completed transfer
//   decode_err()         : classifies a latched access (usable by a scoreboard)
// -----------------------------------------------------------------------------
package apb_reg_bank_pkg;

  localparam int unsigned REG_STRIDE = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_reg_bank_state_e;

  typedef enum logic [1:0] {
    OK,
    RANGE,
    ALIGN,
    RO
  } dec_err_e;

  // below_base : address was lower than the bank base
  // off        : address minus base, zero-extended to 64 bits
  // ro_bit     : read-only flag of the addressed register (ignored when out of range)
  function automatic dec_err_e decode_err(input logic below_base,
                                          input logic [63:0] off,
                                          input int unsigned num_regs,
                                          input logic write,
                                          input logic ro_bit);
    if (below_base || (off >= 64'(num_regs) * 64'(REG_STRIDE))) return RANGE;
    if (off[1:0] != 2'b00) return ALIGN;
    if (write && ro_bit) return RO;
    return OK;
  endfunction

endpackage

// File: rtl/apb_reg_bank_access_ctrl.sv
// -----------------------------------------------------------------------------
// apb_access_ctrl
// APB3 completer handshake: IDLE/ACCESS FSM with programmable wait states.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   psel, penable, pwrite    : APB control inputs
//   paddr, pwdata            : APB address / write data
//   pready                   : transfer completes this cycle
//   commit                   : completing transfer is a write (write lands on this edge)
//   lat_addr/lat_write/lat_wdata : transfer attributes captured in the setup cycle
// -----------------------------------------------------------------------------
module apb_access_ctrl
  import apb_reg_bank_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic              commit,
  output logic [ADDR_W-1:0] lat_addr,
  output logic              lat_write,
  output logic [DATA_W-1:0] lat_wdata
);

  apb_reg_bank_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       setup;

  assign setup = (state == IDLE) && psel && !penable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Transfer attributes are pure data: captured on setup, never reset.
  always_ff @(posedge clk) begin
    if (setup) begin
      lat_addr  <= paddr;
      lat_write <= pwrite;
      lat_wdata <= pwdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pready    = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Requester abandoned the transfer: drop it silently.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (penable) begin
          // Reset in the completion cycle wins over the handshake.
          pready    = !rst;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign commit = pready && lat_write;

endmodule

// File: rtl/apb_reg_bank.sv
// -----------------------------------------------------------------------------
// apb_reg_bank
// APB3 completer holding NUM_REGS software-visible registers with wait states,
// read-only mask, decode-fault PSLVERR and a per-register hardware update path.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   apbReg_*            : flattened APB3 completer interface
//   reg_q               : registered contents, reg i at [i*DATA_W +: DATA_W]
//   reg_wr_pulse        : one-cycle pulse after a successful APB write to reg i
//   hw_we, hw_wdata     : hardware write enable / data per register
// -----------------------------------------------------------------------------
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int                    ADDR_W      = 32,
  parameter int                    DATA_W      = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]     BASE_ADDR   = 32'h0000_1000,
  parameter int                    WAIT_STATES = 2,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = 8'h80,
  parameter logic [DATA_W-1:0]     RST_VAL     = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            apbReg_paddr,
  input  logic                         apbReg_psel,
  input  logic                         apbReg_penable,
  input  logic                         apbReg_pwrite,
  input  logic [DATA_W-1:0]            apbReg_pwdata,
  output logic                         apbReg_pready,
  output logic [DATA_W-1:0]            apbReg_prdata,
  output logic                         apbReg_pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  input  logic [NUM_REGS-1:0]          hw_we,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              done;
  logic              commit;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [DATA_W-1:0] lat_wdata;

  apb_access_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_STATES (WAIT_STATES)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .psel      (apbReg_psel),
    .penable   (apbReg_penable),
    .pwrite    (apbReg_pwrite),
    .paddr     (apbReg_paddr),
    .pwdata    (apbReg_pwdata),
    .pready    (done),
    .commit    (commit),
    .lat_addr  (lat_addr),
    .lat_write (lat_write),
    .lat_wdata (lat_wdata)
  );

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              below_base;
  logic              ro_bit;
  logic [DATA_W-1:0] rd_val;
  dec_err_e          err_code;
  logic              err;
  logic              apb_wr;

  // Offset wraps in ADDR_W, so addresses below base land far out of range too.
  assign off        = lat_addr - BASE_ADDR;
  assign idx        = off[IDX_W+1:2];
  assign below_base = lat_addr < BASE_ADDR;

  // idx is only meaningful when in range; the range check has priority anyway.
  always_comb begin
    ro_bit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        ro_bit = RO_MASK[i];
        rd_val = regs[i];
      end
    end
  end

  assign err_code = decode_err(below_base, 64'(off), NUM_REGS, lat_write, ro_bit);
  assign err      = (err_code != OK);
  assign apb_wr   = commit && !err;

  assign apbReg_pready  = done;
  assign apbReg_pslverr = done && err;
  assign apbReg_prdata  = (done && !err && !lat_write) ? rd_val : '0;

  // APB write is applied after the hardware load so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hw_we[i]) regs[i] <= hw_wdata[i*DATA_W +: DATA_W];
        if (apb_wr && (idx == IDX_W'(i))) regs[i] <= lat_wdata;
        reg_wr_pulse[i] <= apb_wr && (idx == IDX_W'(i));
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
module tb_apb_reg_bank;
  import apb_reg_bank_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  paddr;
  logic         penable, pwrite;
  logic [31:0]  pwdata;
  logic         psel0, psel1;
  logic [7:0]   hw_we0, hw_we1;
  logic [255:0] hw_wdata0, hw_wdata1;

  logic         pready0, pslverr0, pready1, pslverr1;
  logic [31:0]  prdata0, prdata1;
  logic [255:0] reg_q0, reg_q1;
  logic [7:0]   pulse0, pulse1;

  apb_reg_bank #(.WAIT_STATES(2)) dut0 (
    .clk(clk), .rst(rst),
    .apbReg_paddr(paddr), .apbReg_psel(psel0), .apbReg_penable(penable),
    .apbReg_pwrite(pwrite), .apbReg_pwdata(pwdata),
    .apbReg_pready(pready0), .apbReg_prdata(prdata0), .apbReg_pslverr(pslverr0),
    .reg_q(reg_q0), .reg_wr_pulse(pulse0), .hw_we(hw_we0), .hw_wdata(hw_wdata0)
  );

  apb_reg_bank #(.WAIT_STATES(0)) dut1 (
    .clk(clk), .rst(rst),
    .apbReg_paddr(paddr), .apbReg_psel(psel1), .apbReg_penable(penable),
    .apbReg_pwrite(pwrite), .apbReg_pwdata(pwdata),
    .apbReg_pready(pready1), .apbReg_prdata(prdata1), .apbReg_pslverr(pslverr1),
    .reg_q(reg_q1), .reg_wr_pulse(pulse1), .hw_we(hw_we1), .hw_wdata(hw_wdata1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model0 [8];
  logic [31:0] model1 [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(input int sel);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = (sel == 0) ? model0[i] : model1[i];
    return p;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? pready0 : pready1;
  endfunction

  // One APB transfer; the expectation is queued when driven and popped on pready.
  task automatic xfer(input int sel, input logic [31:0] a, input logic wr,
                      input logic [31:0] wd, input logic [31:0] erd,
                      input logic eerr, input int elat, input string tag);
    exp_t e;
    int   cyc;
    bit   got;
    e.rdata = erd; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    @(posedge clk); #1;
    paddr = a; pwrite = wr; pwdata = wd; penable = 1'b0;
    if (sel == 0) psel0 = 1'b1; else psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1; got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (rdy(sel)) got = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
    e = sb.pop_front();
    chk({tag, "_done"}, 256'(got), 256'(1'b1));
    if (got) begin
      chk({tag, "_lat"}, 256'(cyc), 256'(e.lat));
      chk({tag, "_slverr"}, 256'((sel == 0) ? pslverr0 : pslverr1), 256'(e.err));
      if (!wr) chk({tag, "_rdata"}, 256'((sel == 0) ? prdata0 : prdata1), 256'(e.rdata));
      if (wr && !eerr) begin
        if (sel == 0) model0[a[4:2]] = wd; else model1[a[4:2]] = wd;
      end
    end else begin
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; paddr = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    psel0 = 1'b0; psel1 = 1'b0;
    hw_we0 = '0; hw_we1 = '0; hw_wdata0 = '0; hw_wdata1 = '0;
    for (int i = 0; i < 8; i++) begin model0[i] = '0; model1[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pready",  256'(pready0),  256'(1'b0));
    chk("rst_prdata",  256'(prdata0),  256'(32'h0));
    chk("rst_pslverr", 256'(pslverr0), 256'(1'b0));
    chk("rst_pulse",   256'(pulse0),   256'(8'h0));
    chk("rst_regq",    reg_q0,         256'(0));

    // Write then read back with two wait states
    xfer(0, 32'h1004, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 3, "wr_1004");
    @(negedge clk);
    chk("pulse_after_wr", 256'(pulse0), 256'(8'h02));
    chk("regq_after_wr",  reg_q0,       pack(0));
    @(negedge clk);
    chk("pulse_cleared",  256'(pulse0), 256'(8'h00));
    xfer(0, 32'h1004, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, "rd_1004");

    // Decode faults
    xfer(0, 32'h101C, 1'b1, 32'h5, 32'h0, 1'b1, 3, "wr_ro");
    @(negedge clk);
    chk("ro_pulse", 256'(pulse0), 256'(8'h00));
    chk("ro_regq",  reg_q0,       pack(0));
    xfer(0, 32'h1020, 1'b0, 32'h0, 32'h0, 1'b1, 3, "rd_range");
    xfer(0, 32'h1002, 1'b0, 32'h0, 32'h0, 1'b1, 3, "rd_align");
    xfer(0, 32'h0FFC, 1'b0, 32'h0, 32'h0, 1'b1, 3, "rd_below");
    xfer(0, 32'h101C, 1'b0, 32'h0, 32'h0, 1'b0, 3, "rd_ro_ok");
    idle();
    @(negedge clk);
    chk("err_regq", reg_q0, pack(0));

    // Zero wait states, back-to-back writes
    xfer(1, 32'h1000, 1'b1, 32'h11, 32'h0, 1'b0, 1, "b2b_wr0");
    xfer(1, 32'h1008, 1'b1, 32'h22, 32'h0, 1'b0, 1, "b2b_wr2");
    idle();
    @(negedge clk);
    chk("b2b_reg0", 256'(reg_q1[31:0]),  256'(32'h11));
    chk("b2b_reg2", 256'(reg_q1[95:64]), 256'(32'h22));
    chk("b2b_regq", reg_q1, pack(1));

    // APB write collides with hw update to reg3; hw update to reg4 proceeds
    hw_wdata0[3*32 +: 32] = 32'h0000A5A5;
    hw_wdata0[4*32 +: 32] = 32'h00004444;
    hw_we0 = 8'h18;
    xfer(0, 32'h100C, 1'b1, 32'h00005A5A, 32'h0, 1'b0, 3, "wr_coll");
    @(posedge clk); #1;
    hw_we0 = '0;
    psel0 = 1'b0; penable = 1'b0;
    model0[4] = 32'h00004444;
    @(negedge clk);
    chk("coll_reg3", 256'(reg_q0[3*32 +: 32]), 256'(32'h00005A5A));
    chk("coll_regq", reg_q0, pack(0));

    // Hardware-only update, including the read-only register
    @(posedge clk); #1;
    hw_wdata0[7*32 +: 32] = 32'h00007777;
    hw_we0 = 8'h88;
    @(posedge clk); #1;
    hw_we0 = '0;
    model0[3] = 32'h0000A5A5;
    model0[7] = 32'h00007777;
    @(negedge clk);
    chk("hw_reg3", 256'(reg_q0[3*32 +: 32]), 256'(32'h0000A5A5));
    chk("hw_regq", reg_q0, pack(0));
    xfer(0, 32'h101C, 1'b0, 32'h0, 32'h00007777, 1'b0, 3, "rd_hw_ro");

    // Reset during ACCESS (cnt=1) of a write
    @(posedge clk); #1;
    paddr = 32'h1000; pwrite = 1'b1; pwdata = 32'h77; penable = 1'b0; psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pready_a", 256'(pready0), 256'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0; psel0 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 8; i++) begin model0[i] = '0; model1[i] = '0; end
    @(negedge clk);
    chk("rstmid_pready_b", 256'(pready0), 256'(1'b0));
    chk("rstmid_regq",     reg_q0,        pack(0));
    xfer(0, 32'h1000, 1'b1, 32'h77, 32'h0, 1'b0, 3, "post_rst_wr");
    xfer(0, 32'h1000, 1'b0, 32'h0, 32'h77, 1'b0, 3, "post_rst_rd");

    // psel dropped mid-ACCESS on a write
    @(posedge clk); #1;
    paddr = 32'h1000; pwrite = 1'b1; pwdata = 32'h99; penable = 1'b0; psel0 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready0 || pulse0 != 8'h0) seen = 1'b1;
    end
    chk("drop_no_ready", 256'(seen), 256'(1'b0));
    chk("drop_regq",     reg_q0,     pack(0));
    xfer(0, 32'h1000, 1'b0, 32'h0, 32'h77, 1'b0, 3, "drop_rd");
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
